wbs_checkbit_port: RTL

Wishbone-slave status port that drives the 16-bit checkbit field on user pads mprj_io[31:16], where the chip-level benches watch for progress/pass codes (e.g. 16'hAB60 start, 16'hAB6A pass). It sits between the user-project Wishbone bus (wb_host side) and the pad output/OEB muxing, directly upstream of the pads the bench samples. Firmware writes codes; the block also flags the pass/fail codes and runs a watchdog that replaces the pad value with a timeout code if firmware stalls.

---
 rtl/wbs_checkbit_port.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wbs_checkbit_port.sv
// Wishbone status port driving the 16-bit checkbit pads, with pass/fail flags
// and a watchdog that substitutes a timeout code when firmware stops writing.
module wbs_checkbit_port #(
    parameter logic [15:0] PASS_CODE = 16'hAB6A,
    parameter logic [15:0] FAIL_CODE = 16'hAB6F,
    parameter logic [15:0] TO_CODE   = 16'hABEE,
    parameter int unsigned WDOG_W    = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [15:0] checkbits_o,
    output logic [15:0] checkbits_oeb_o,
    output logic        pass_o,
    output logic        wdog_irq_o
);

    localparam logic [1:0] REG_CODE   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_WLOAD  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic              ack_q,   ack_d;
    logic [31:0]       dat_q,   dat_d;
    logic [15:0]       code_q,  code_d;
    logic              oe_q,    oe_d;
    logic              en_q,    en_d;
    logic [WDOG_W-1:0] load_q,  load_d;
    logic [WDOG_W-1:0] cnt_q,   cnt_d;
    logic              exp_q,   exp_d;
    logic              pass_q,  pass_d;
    logic              fail_q,  fail_d;
    logic [7:0]        wcnt_q,  wcnt_d;
    logic [15:0]       cb_q,    cb_d;
    logic [15:0]       oeb_q,   oeb_d;

    logic        access, wr, rd;
    logic        code_wr, clr, expire;
    logic [31:0] bmask;
    logic [31:0] rdata;

    always_comb begin
        access  = wbs_cyc_i & wbs_stb_i & ~ack_q;
        wr      = access & wbs_we_i;
        rd      = access & ~wbs_we_i;
        bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
        code_wr = 1'b0;
        clr     = 1'b0;
        expire  = 1'b0;

        ack_d  = access;
        dat_d  = '0;
        code_d = code_q;
        oe_d   = oe_q;
        en_d   = en_q;
        load_d = load_q;
        cnt_d  = cnt_q;

        unique case (wbs_adr_i[3:2])
            REG_CODE:   rdata = {16'h0, code_q};
            REG_CTRL:   rdata = {30'h0, en_q, oe_q};
            REG_WLOAD:  rdata = 32'(load_q);
            REG_STATUS: rdata = {16'h0, wcnt_q, 5'h0, fail_q, pass_q, exp_q};
            default:    rdata = '0;
        endcase
        if (rd)
            dat_d = rdata;

        // Watchdog tick; a load of 0 or 1 expires on the following edge.
        if (en_q && !exp_q) begin
            if (cnt_q <= WDOG_W'(1)) begin
                cnt_d  = '0;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q - WDOG_W'(1);
            end
        end

        if (wr) begin
            unique case (wbs_adr_i[3:2])
                REG_CODE: begin
                    code_wr = |wbs_sel_i;
                    code_d  = (code_q & ~bmask[15:0]) | (wbs_dat_i[15:0] & bmask[15:0]);
                end
                REG_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        oe_d = wbs_dat_i[0];
                        en_d = wbs_dat_i[1];
                        clr  = wbs_dat_i[2];
                        if (wbs_dat_i[1] && !en_q)
                            cnt_d = load_q;
                    end
                end
                REG_WLOAD:
                    load_d = (load_q & ~bmask[WDOG_W-1:0]) | (wbs_dat_i[WDOG_W-1:0] & bmask[WDOG_W-1:0]);
                default: ;
            endcase
        end

        // A code write is proof of life: it reloads and overrides a same-cycle expiry.
        if (code_wr) begin
            cnt_d  = load_q;
            expire = 1'b0;
        end

        exp_d  = (clr ? 1'b0 : exp_q) | expire;
        pass_d = (clr ? 1'b0 : pass_q) | (code_wr && code_d == PASS_CODE);
        fail_d = (clr ? 1'b0 : fail_q) | (code_wr && code_d == FAIL_CODE);
        wcnt_d = (clr ? 8'h00 : wcnt_q) + 8'(code_wr);

        cb_d  = exp_q ? TO_CODE : code_q;
        oeb_d = {16{~oe_q}};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            code_q <= '0;
            oe_q   <= 1'b0;
            en_q   <= 1'b0;
            load_q <= '1;
            cnt_q  <= '0;
            exp_q  <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            wcnt_q <= '0;
            cb_q   <= '0;
            oeb_q  <= '1;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            code_q <= code_d;
            oe_q   <= oe_d;
            en_q   <= en_d;
            load_q <= load_d;
            cnt_q  <= cnt_d;
            exp_q  <= exp_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            wcnt_q <= wcnt_d;
            cb_q   <= cb_d;
            oeb_q  <= oeb_d;
        end
    end

    assign wbs_ack_o       = ack_q;
    assign wbs_dat_o       = dat_q;
    assign checkbits_o     = cb_q;
    assign checkbits_oeb_o = oeb_q;
    assign pass_o          = pass_q;
    assign wdog_irq_o      = exp_q;

endmodule
